// File: rtl/step_counter_pkg.sv
// Shared definitions for the step down-counter: step codes, FSM states, step decode helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package step_counter_pkg;

   // Step control codes on the c input
   localparam logic [1:0] STEP_DEC3     = 2'b00;
   localparam logic [1:0] STEP_DEC1     = 2'b01;
   localparam logic [1:0] STEP_HOLD_ALT = 2'b10;
   localparam logic [1:0] STEP_HOLD     = 2'b11;

   // Counter FSM; IDLE is only reachable through reset
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // True when the step code actually decrements (both hold codes return 0)
   function automatic logic step_active(input logic [1:0] code);
      return (code == STEP_DEC3) || (code == STEP_DEC1);
   endfunction

   // Decrement magnitude for a step code; hold codes map to 0
   function automatic logic [1:0] step_mag(input logic [1:0] code);
      logic [1:0] mag;
      mag = 2'd0;
      case (code)
         STEP_DEC3: mag = 2'd3;
         STEP_DEC1: mag = 2'd1;
         default:   mag = 2'd0;
      endcase
      return mag;
   endfunction

endpackage

// File: rtl/step_sub.sv
// Clamped subtractor: diff = max(a - step, 0), plus hit (a <= step) and under (a < step).
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module step_sub #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] step,
   output logic [WIDTH-1:0] diff,
   output logic             hit,
   output logic             under
);

   // One extra bit so an underflow shows up as the MSB instead of wrapping
   logic [WIDTH:0] ext_diff;

   // Extended subtraction; MSB set means step exceeded a
   always_comb begin
      ext_diff = {1'b0, a} - {1'b0, step};
      under    = ext_diff[WIDTH];
      hit      = ext_diff[WIDTH] || (ext_diff[WIDTH-1:0] == '0);
      diff     = ext_diff[WIDTH] ? '0 : ext_diff[WIDTH-1:0];
   end

endmodule

// File: rtl/step_downcounter.sv
// Loadable down-counter stepping by 3, 1 or holding; pulses done/borrow when it reaches or crosses zero.
// Latency: count, done and borrow are registered, one cycle after the controlling inputs.
// Backpressure: none; load wins over count_en, count_en is ignored outside RUN.
// Optional feature: define STEP_DOWNCOUNTER_AUTO_RELOAD_EN to reload from the last loaded value
// on a terminal event instead of stopping in DONE. WIDTH must be at least 2 so a step of 3 fits.
module step_downcounter
   import step_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             count_en,
   input  logic [1:0]       c,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             borrow
);

   state_t           state;
   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] next_diff;
   logic             step_hit;
   logic             step_under;
   logic             do_step;

`ifdef STEP_DOWNCOUNTER_AUTO_RELOAD_EN
   // Last value loaded; restored on every terminal event
   logic [WIDTH-1:0] reload_reg;
`endif

   // Decode the step code into a WIDTH-wide decrement and a "this cycle counts" flag
   always_comb begin
      step    = WIDTH'(step_mag(c));
      do_step = (state == RUN) && count_en && step_active(c);
   end

   step_sub #(
      .WIDTH (WIDTH)
   ) u_step_sub (
      .a     (count),
      .step  (step),
      .diff  (next_diff),
      .hit   (step_hit),
      .under (step_under)
   );

   // Status outputs derived straight from registered state
   always_comb begin
      zero = (count == '0);
      busy = (state == RUN);
   end

   // Counter FSM: load has priority, otherwise step while in RUN; done/borrow default low each cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= '0;
         done       <= 1'b0;
         borrow     <= 1'b0;
`ifdef STEP_DOWNCOUNTER_AUTO_RELOAD_EN
         reload_reg <= '0;
`endif
      end else begin
         done   <= 1'b0;
         borrow <= 1'b0;
         if (load) begin
            // A zero load has nothing to count, so go straight to DONE without a pulse
            count <= data_in;
            state <= (data_in != '0) ? RUN : DONE;
`ifdef STEP_DOWNCOUNTER_AUTO_RELOAD_EN
            reload_reg <= data_in;
`endif
         end else if (do_step) begin
            if (step_hit) begin
               done   <= 1'b1;
               borrow <= step_under;
`ifdef STEP_DOWNCOUNTER_AUTO_RELOAD_EN
               // Restart from the loaded value; a zero reload value cannot run, so stop
               count <= reload_reg;
               state <= (reload_reg != '0) ? RUN : DONE;
`else
               count <= '0;
               state <= DONE;
`endif
            end else begin
               count <= next_diff;
            end
         end
      end
   end

   // Terminal-event invariants: borrow only accompanies done, RUN never holds a zero count,
   // and a load never produces a pulse
   a_borrow_with_done : assert property (@(posedge clk) disable iff (!reset)
      borrow |-> done);
   a_run_nonzero : assert property (@(posedge clk) disable iff (!reset)
      (state == RUN) |-> (count != '0));
   a_load_no_pulse : assert property (@(posedge clk) disable iff (!reset)
      load |=> (!done && !borrow));

endmodule

// File: tb/tb_step_downcounter.sv
// Self-checking bench for step_downcounter (WIDTH=4) using a reference model and expectation queue.
// Latency: expectations are pushed when inputs are driven and popped one edge later.
// Backpressure: n/a.
module tb_step_downcounter;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         load;
   logic         count_en;
   logic [1:0]   c;
   logic [W-1:0] data_in;
   logic [W-1:0] count;
   logic         zero;
   logic         busy;
   logic         done;
   logic         borrow;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string tag;
      int    count;
      int    zero;
      int    busy;
      int    done;
      int    borrow;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state: 0 = IDLE, 1 = RUN, 2 = DONE
   int m_count;
   int m_state;
   int m_reload;

   step_downcounter #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .count_en (count_en),
      .c        (c),
      .data_in  (data_in),
      .count    (count),
      .zero     (zero),
      .busy     (busy),
      .done     (done),
      .borrow   (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_count  = 0;
      m_state  = 0;
      m_reload = 0;
   endtask

   // Advance the model by one clock with the given inputs and return the expected outputs
   task automatic model_step(input bit ld, input bit en, input logic [1:0] cc,
                             input int d, input string tag, output exp_t e);
      int stp;
      e.done   = 0;
      e.borrow = 0;
      if (ld) begin
         m_count  = d;
         m_reload = d;
         m_state  = (d != 0) ? 1 : 2;
      end else if (m_state == 1 && en && (cc == 2'b00 || cc == 2'b01)) begin
         stp = (cc == 2'b00) ? 3 : 1;
         if (m_count > stp) begin
            m_count = m_count - stp;
         end else begin
            e.done   = 1;
            e.borrow = (m_count < stp) ? 1 : 0;
`ifdef STEP_DOWNCOUNTER_AUTO_RELOAD_EN
            m_count = m_reload;
            m_state = (m_reload != 0) ? 1 : 2;
`else
            m_count = 0;
            m_state = 2;
`endif
         end
      end
      e.tag   = tag;
      e.count = m_count;
      e.zero  = (m_count == 0) ? 1 : 0;
      e.busy  = (m_state == 1) ? 1 : 0;
   endtask

   // Drive one cycle of stimulus at the falling edge, queue the expectation, compare after the rising edge
   task automatic drive(input bit ld, input bit en, input logic [1:0] cc, input int d, input string tag);
      exp_t e;
      exp_t got_e;
      @(negedge clk);
      load     = ld;
      count_en = en;
      c        = cc;
      data_in  = W'(d);
      model_step(ld, en, cc, d, tag, e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got_e = exp_q.pop_front();
      check({got_e.tag, ".count"},  32'(count),  32'(got_e.count));
      check({got_e.tag, ".zero"},   32'(zero),   32'(got_e.zero));
      check({got_e.tag, ".busy"},   32'(busy),   32'(got_e.busy));
      check({got_e.tag, ".done"},   32'(done),   32'(got_e.done));
      check({got_e.tag, ".borrow"}, 32'(borrow), 32'(got_e.borrow));
   endtask

   initial begin
      reset    = 1'b0;
      load     = 1'b0;
      count_en = 1'b0;
      c        = 2'b10;
      data_in  = '0;
      model_reset();
      #23;
      check("rst.count",  32'(count),  32'd0);
      check("rst.zero",   32'(zero),   32'd1);
      check("rst.busy",   32'(busy),   32'd0);
      check("rst.done",   32'(done),   32'd0);
      check("rst.borrow", 32'(borrow), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // IDLE ignores count_en
      drive(0, 1, 2'b00, 0, "idle_en");

      // Load 9, step by 3 down to exactly zero: done without borrow
      drive(1, 0, 2'b00, 9, "ld9");
      drive(0, 1, 2'b00, 0, "d9_6");
      drive(0, 1, 2'b00, 0, "d9_3");
      drive(0, 1, 2'b00, 0, "d9_0");
      drive(0, 1, 2'b00, 0, "d9_after");

      // Load 5, step by 3: crossing zero gives done and borrow together
      drive(1, 0, 2'b00, 5, "ld5");
      drive(0, 1, 2'b00, 0, "d5_2");
      drive(0, 1, 2'b00, 0, "d5_0");
      drive(0, 1, 2'b01, 0, "d5_after");

      // Load beats count_en in the same cycle
      drive(1, 0, 2'b00, 12, "ld12");
      drive(1, 1, 2'b00, 7, "ld7_en");
      drive(0, 0, 2'b00, 0, "ld7_hold");

      // Hold codes and count_en=0 keep the count
      drive(1, 0, 2'b00, 8, "ld8");
      drive(0, 1, 2'b10, 0, "h10a");
      drive(0, 1, 2'b10, 0, "h10b");
      drive(0, 1, 2'b11, 0, "h11a");
      drive(0, 1, 2'b11, 0, "h11b");
      drive(0, 0, 2'b00, 0, "en0a");
      drive(0, 0, 2'b01, 0, "en0b");

      // Step by 1 from 3; with auto-reload this wraps back to 3
      drive(1, 0, 2'b01, 3, "ld3");
      for (int i = 0; i < 7; i++) drive(0, 1, 2'b01, 0, $sformatf("d1_%0d", i));

      // Zero load lands in DONE with no pulse
      drive(1, 1, 2'b00, 0, "ld0");
      drive(0, 1, 2'b00, 0, "ld0_after");

      // Asynchronous reset in the middle of a run
      drive(1, 0, 2'b00, 7, "ld7");
      drive(0, 1, 2'b01, 0, "d7_6");
      #3;
      reset = 1'b0;
      #1;
      check("arst.count",  32'(count),  32'd0);
      check("arst.busy",   32'(busy),   32'd0);
      check("arst.zero",   32'(zero),   32'd1);
      check("arst.done",   32'(done),   32'd0);
      check("arst.borrow", 32'(borrow), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(0, 1, 2'b00, 0, "post_rst_a");
      drive(0, 1, 2'b01, 0, "post_rst_b");
      drive(1, 0, 2'b00, 4, "post_rst_ld4");
      drive(0, 1, 2'b00, 0, "post_rst_d4");

      // Randomised traffic against the model
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 7) == 0), $urandom_range(0, 3) != 0,
               2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
      end

      if (exp_q.size() != 0) check("queue_drain", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
